excompress: RTL and testbench
=============================

EXCOMPRESS -- requirements
Module: excompress

Interface
REQ-001 SHALL have parameter OPT_LOWPOWER, default 1'b0; when 1, o_word SHALL be all-zero whenever o_stb is low.
REQ-002 SHALL have port i_clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports i_stb (input, 1), o_busy (output, 1) and i_word (input, 35): uncompressed word in, accepted when i_stb && !o_busy.
REQ-005 SHALL have ports o_stb (output, 1), i_busy (input, 1) and o_word (output, 35): compressed word out, consumed when o_stb && !i_busy.
REQ-006 SHALL have port o_active, output, 1, high while any pipeline stage holds a word.

Function
REQ-007 Word type is [34:33]: 00 address, 01 write, 10 read, 11 special; the type SHALL pass unchanged.
REQ-008 Pipeline: 2 registered stages, S1 then output; an accepted word SHALL raise o_stb exactly 2 clocks later when there is no backpressure; throughput 1 word/clock.
REQ-009 Backpressure: o_busy = S1 valid && S1 stalled; S1 stalled = o_stb && i_busy; a stalled o_word/o_stb SHALL hold stable; no word lost or duplicated.
REQ-010 Address input is {00, rel, w[31:2], x, inc}; bit 1 ignored; encodings listed shortest first, first fit chosen.
REQ-011 Rel 2-bit: if rel and w[31:3] uniform: {00,10,w[3:2],inc,28'h0}.
REQ-012 7-bit: if w[31:8] uniform: {00,110,rel,w[8:2],inc,21'h0}.
REQ-013 14-bit: if w[31:15] uniform, or rel (truncated, out-of-range rel unsupported): {00,111,rel,w[15:2],inc,14'h0}.
REQ-014 Abs full otherwise: {00,0,w[31:2],0,inc}.
REQ-015 Read input: count = i_word[11:0]; count 0 SHALL encode as 1; count >2064 SHALL encode as 2064.
REQ-016 Read encoding: count 1..16 -> {10,0,(count-1)[3:0],28'h0}; count 17..2064 -> {10,1,(count-17)[10:0],21'h0}.
REQ-017 Special: {11,i_word[32:28],28'h0}.
REQ-018 Write input: d = i_word[31:0]; history = last 8 table-written values, distance 1 = newest, plus valid count 0..8.
REQ-019 Write priority, first match wins:
  - (a) d[31:8] uniform -> {01,110,d[8:0],21'h0};
  - (b) d equals a valid history entry at smallest distance k, k=1..4 -> {01,100,(k-1)[1:0],28'h0};
  - (c) same, k=5..8 -> {01,101,(k-1)[8:0],21'h0};
  - (d) d[31:15] uniform -> {01,111,d[15:0],14'h0};
  - (e) otherwise {01,0,d}.
REQ-020 Only encodings (d) and (e) SHALL push d into history (shift, valid count saturating at 8); (a), (b), (c) SHALL NOT.
REQ-021 History update SHALL occur on the accepting edge, so back-to-back writes compare against all prior writes.
REQ-022 Invalid history entries SHALL never match.
REQ-023 Matching, encoding selection and history update SHALL be computed from i_word at acceptance; the output stage only formats.
REQ-024 o_active = S1 valid || o_stb.

Reset
REQ-025 i_reset SHALL clear S1 valid, o_stb and history valid count to 0, including mid-stream; in-flight words are discarded.
REQ-026 o_busy SHALL be 0 in the cycle after reset.
REQ-027 History must reset together with the far-end decompressor's table pointer.
REQ-028 With OPT_LOWPOWER=1, reset SHALL also zero o_word and the history data.

Verification
REQ-029 Write 0x12345678, then write 0x12345678 -> outputs {01,0,0x12345678}, then {01,100,00,28'h0}; then write 0x12345678 again -> short hit again, and history is not pushed by the hits.
REQ-030 Write 0x00000005 -> {01,110,9'h005,21'h0}; write 0xFFFF8000 -> {01,111,16'h8000,14'h0}, pushed into history; write 0xFFFF8000 again -> distance-1 hit.
REQ-031 Read count 16 -> {10,0,4'hF,28'h0}; count 17 -> {10,1,11'h000,21'h0}; count 2064 -> {10,1,11'h7FF,21'h0}; count 0 -> {10,0,4'h0,28'h0}.
REQ-032 Address abs w[31:2]=0x10, inc=1 -> 7-bit form {00,110,0,7'h10,1,21'h0}; rel offset -1 -> {00,10,2'b11,inc,28'h0}.
REQ-033 Backpressure: hold i_busy=1 for 5 clocks with 3 words queued -> o_word stable, o_busy high, words emerge in order once released.
REQ-034 Reset after 9 full writes, then repeat the first value -> full encoding, no history hit.

Source files
------------

// File: rtl/excompress_if.sv
// Handshake bundle for the word compressor: uncompressed words in, compressed words out.
// The slave modport is the compressor's view; master is the producer/consumer side.
interface excompress_if;
    logic        i_stb;
    logic        o_busy;
    logic [34:0] i_word;
    logic        o_stb;
    logic        i_busy;
    logic [34:0] o_word;

    modport slave  (input  i_stb, i_word, i_busy, output o_busy, o_stb, o_word);
    modport master (output i_stb, i_word, i_busy, input  o_busy, o_stb, o_word);
endinterface

// File: rtl/excompress.sv
// Two-stage bus-word compressor: S1 holds the fully encoded word, the output stage presents it.
// Encoding choice and write-history update are resolved from i_word on the accepting edge.
module excompress #(
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    excompress_if.slave       bus,
    output logic              o_active
);
    typedef logic [34:0] word_t;

    logic        s1_vld_q, s1_vld_d;
    word_t       s1_word_q, s1_word_d;
    logic        o_stb_q, o_stb_d;
    word_t       o_word_q, o_word_d;
    logic [31:0] hist_q [8];
    logic [31:0] hist_d [8];
    logic [3:0]  hist_cnt_q, hist_cnt_d;

    logic        out_adv, accept, push;
    word_t       enc;
    logic [31:0] w, aw;
    logic        rel, inc, hit;
    logic [2:0]  hit_idx;
    logic [11:0] cnt, cm1, cm17;

    // True when bits [31:lsb] are a pure sign extension.
    function automatic logic fits_signed(input logic [31:0] v, input int lsb);
        logic [31:0] ext;
        ext = 32'($signed(v) >>> lsb);
        return (ext == '0) || (&ext);
    endfunction

    function automatic logic [11:0] sat_count(input logic [11:0] c);
        if (c == 12'd0)
            return 12'd1;
        if (c > 12'd2064)
            return 12'd2064;
        return c;
    endfunction

    assign out_adv     = !o_stb_q || !bus.i_busy;
    assign bus.o_busy  = s1_vld_q && o_stb_q && bus.i_busy;
    assign accept      = bus.i_stb && !bus.o_busy;
    assign bus.o_stb   = o_stb_q;
    assign bus.o_word  = o_word_q;
    assign o_active    = s1_vld_q || o_stb_q;

    always_comb begin
        enc     = '0;
        push    = 1'b0;
        w       = bus.i_word[31:0];
        aw      = {bus.i_word[31:2], 2'b00};
        rel     = bus.i_word[32];
        inc     = bus.i_word[0];
        hit     = 1'b0;
        hit_idx = '0;
        cnt     = sat_count(bus.i_word[11:0]);
        cm1     = cnt - 12'd1;
        cm17    = cnt - 12'd17;
        // Descending scan so the nearest valid entry wins.
        for (int i = 7; i >= 0; i--) begin
            if (4'(i) < hist_cnt_q && hist_q[i] == w) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
        case (bus.i_word[34:33])
            2'b00: begin
                if (rel && fits_signed(aw, 3))
                    enc = {2'b00, 2'b10, aw[3:2], inc, 28'h0};
                else if (fits_signed(aw, 8))
                    enc = {2'b00, 3'b110, rel, aw[8:2], inc, 21'h0};
                else if (fits_signed(aw, 15) || rel)
                    enc = {2'b00, 3'b111, rel, aw[15:2], inc, 14'h0};
                else
                    enc = {2'b00, 1'b0, aw[31:2], 1'b0, inc};
            end
            2'b01: begin
                if (fits_signed(w, 8))
                    enc = {2'b01, 3'b110, w[8:0], 21'h0};
                else if (hit && !hit_idx[2])
                    enc = {2'b01, 3'b100, hit_idx[1:0], 28'h0};
                else if (hit)
                    enc = {2'b01, 3'b101, 6'h0, hit_idx, 21'h0};
                else if (fits_signed(w, 15)) begin
                    enc  = {2'b01, 3'b111, w[15:0], 14'h0};
                    push = 1'b1;
                end else begin
                    enc  = {2'b01, 1'b0, w};
                    push = 1'b1;
                end
            end
            2'b10: begin
                if (cnt <= 12'd16)
                    enc = {2'b10, 1'b0, cm1[3:0], 28'h0};
                else
                    enc = {2'b10, 1'b1, cm17[10:0], 21'h0};
            end
            default: enc = {2'b11, bus.i_word[32:28], 28'h0};
        endcase
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_word_d  = s1_word_q;
        o_stb_d    = o_stb_q;
        o_word_d   = o_word_q;
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        if (out_adv) begin
            o_stb_d  = s1_vld_q;
            o_word_d = (OPT_LOWPOWER && !s1_vld_q) ? '0 : s1_word_q;
        end
        if (!bus.o_busy) begin
            s1_vld_d  = bus.i_stb;
            s1_word_d = enc;
        end
        if (accept && push) begin
            for (int i = 7; i > 0; i--)
                hist_d[i] = hist_q[i-1];
            hist_d[0] = w;
            if (hist_cnt_q != 4'd8)
                hist_cnt_d = hist_cnt_q + 4'd1;
        end
        // Reset must line up with the decompressor's table pointer, so history empties too.
        if (i_reset) begin
            s1_vld_d   = 1'b0;
            o_stb_d    = 1'b0;
            hist_cnt_d = '0;
            if (OPT_LOWPOWER) begin
                o_word_d = '0;
                for (int i = 0; i < 8; i++)
                    hist_d[i] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        s1_vld_q   <= s1_vld_d;
        s1_word_q  <= s1_word_d;
        o_stb_q    <= o_stb_d;
        o_word_q   <= o_word_d;
        hist_q     <= hist_d;
        hist_cnt_q <= hist_cnt_d;
    end
endmodule

// File: tb/tb_excompress.sv
// Randomized and directed bench for excompress against a queue-based reference of the encoding rules.
module tb_excompress;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_active;
    int   checks = 0;
    int   failures = 0;

    excompress_if bus();
    excompress #(.OPT_LOWPOWER(1'b1)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .bus      (bus),
        .o_active (o_active)
    );

    always #5 clk = ~clk;

    logic [34:0] exp_q [$];
    logic [31:0] hist [$];
    logic [34:0] out_log [$];
    logic [31:0] pool [16];
    bit          prev_stall = 1'b0;
    logic [34:0] prev_word;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Value fits as a signed number of n+1 bits, i.e. bits [31:n] are uniform.
    function automatic bit fits(input logic [31:0] v, input int n);
        longint s, lim;
        s   = longint'($signed(v));
        lim = longint'(1) << n;
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic logic [34:0] model(input logic [34:0] wd);
        logic [34:0] r;
        logic [31:0] d, a;
        logic        rel, inc;
        int          c, k;
        d = wd[31:0];
        a = {wd[31:2], 2'b00};
        rel = wd[32];
        inc = wd[0];
        case (wd[34:33])
            2'b00: begin
                if (rel && fits(a, 3))       r = {2'b00, 2'b10, a[3:2], inc, 28'h0};
                else if (fits(a, 8))         r = {2'b00, 3'b110, rel, a[8:2], inc, 21'h0};
                else if (fits(a, 15) || rel) r = {2'b00, 3'b111, rel, a[15:2], inc, 14'h0};
                else                         r = {2'b00, 1'b0, a[31:2], 1'b0, inc};
            end
            2'b01: begin
                k = -1;
                foreach (hist[i]) if (k < 0 && hist[i] == d) k = i;
                if (fits(d, 8))              r = {2'b01, 3'b110, d[8:0], 21'h0};
                else if (k >= 0 && k < 4)    r = {2'b01, 3'b100, 2'(k), 28'h0};
                else if (k >= 4)             r = {2'b01, 3'b101, 9'(k), 21'h0};
                else begin
                    if (fits(d, 15)) r = {2'b01, 3'b111, d[15:0], 14'h0};
                    else             r = {2'b01, 1'b0, d};
                    hist.push_front(d);
                    if (hist.size() > 8) void'(hist.pop_back());
                end
            end
            2'b10: begin
                c = int'(d[11:0]);
                if (c == 0) c = 1;
                if (c > 2064) c = 2064;
                if (c <= 16) r = {2'b10, 1'b0, 4'(c - 1), 28'h0};
                else         r = {2'b10, 1'b1, 11'(c - 17), 21'h0};
            end
            default: r = {2'b11, wd[32:28], 28'h0};
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hist.delete();
            prev_stall = 1'b0;
        end else begin
            chk1("active", o_active, exp_q.size() != 0);
            if (!bus.o_stb) chk("idle_word_zero", bus.o_word, 35'h0);
            if (prev_stall) begin
                chk1("stall_stb", bus.o_stb, 1'b1);
                chk("stall_word", bus.o_word, prev_word);
            end
            prev_stall = bus.o_stb && bus.i_busy;
            prev_word  = bus.o_word;
            if (bus.o_stb && !bus.i_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h expected none", bus.o_word);
                end else begin
                    chk("out_word", bus.o_word, exp_q.pop_front());
                end
                out_log.push_back(bus.o_word);
            end
            if (bus.i_stb && !bus.o_busy) exp_q.push_back(model(bus.i_word));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync();
        rst = 1'b1;
        bus.i_stb = 1'b0;
        bus.i_busy = 1'b0;
        sync();
        rst = 1'b0;
    endtask

    task automatic send(input logic [34:0] wd);
        int n = 0;
        bit acc = 1'b0;
        bus.i_stb = 1'b1;
        bus.i_word = wd;
        do begin
            @(negedge clk);
            acc = !bus.o_busy;
            sync();
            n++;
        end while (!acc && n < 50);
        bus.i_stb = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got busy expected accept");
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.i_busy = 1'b0;
        @(negedge clk);
        while (o_active && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (o_active) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got active expected idle");
        end
        sync();
    endtask

    task automatic expect_log(input string nm, input int idx, input logic [34:0] exp);
        if (idx < out_log.size()) chk(nm, out_log[idx], exp);
        else begin
            checks++;
            failures++;
            $display("FAIL %s: got none expected %h", nm, exp);
        end
    endtask

    function automatic logic [34:0] rand_word();
        logic [34:0] r;
        int          off;
        case ($urandom_range(0, 3))
            0: begin
                case ($urandom_range(0, 3))
                    0: off = int'($urandom_range(0, 3)) - 2;
                    1: off = int'($urandom_range(0, 127)) - 64;
                    2: off = int'($urandom_range(0, 16383)) - 8192;
                    default: off = int'($urandom);
                endcase
                r = {2'b00, 1'($urandom), 30'(off), 1'($urandom), 1'($urandom)};
            end
            1: r = {2'b01, 1'b0, pool[$urandom_range(0, 15)]};
            2: begin
                case ($urandom_range(0, 3))
                    0: off = int'($urandom_range(0, 20));
                    1: off = int'($urandom_range(2060, 2070));
                    default: off = int'($urandom_range(0, 4095));
                endcase
                r = {2'b10, 21'($urandom), 12'(off)};
            end
            default: r = {2'b11, 33'({$urandom, 1'b0})};
        endcase
        return r;
    endfunction

    localparam logic [31:0] A = 32'h1234_5678;
    localparam logic [31:0] B = 32'h9ABC_DEF0;

    initial begin
        bus.i_stb = 1'b0;
        bus.i_busy = 1'b0;
        bus.i_word = '0;
        pool[0] = A;            pool[1] = 32'hFFFF_8000; pool[2] = 32'h0000_0005;
        pool[3] = 32'hFFFF_FF00; pool[4] = 32'h0000_0100; pool[5] = 32'h0000_7FFF;
        pool[6] = 32'h0000_8000; pool[7] = B;
        for (int i = 8; i < 16; i++) pool[i] = $urandom;

        do_reset();
        @(negedge clk);
        chk1("reset_stb", bus.o_stb, 1'b0);
        chk1("reset_busy", bus.o_busy, 1'b0);
        chk1("reset_active", o_active, 1'b0);
        chk("reset_word", bus.o_word, 35'h0);
        sync();

        // Address forms and two-clock latency.
        out_log.delete();
        send({2'b00, 1'b0, 30'h10, 1'b0, 1'b1});
        @(negedge clk);
        chk1("latency_1clk", bus.o_stb, 1'b0);
        @(negedge clk);
        chk1("latency_2clk", bus.o_stb, 1'b1);
        drain();
        send({2'b00, 1'b1, 30'h3FFF_FFFF, 1'b0, 1'b0});
        drain();
        expect_log("addr_abs7", 0, {2'b00, 3'b110, 1'b0, 7'h10, 1'b1, 21'h0});
        expect_log("addr_rel2", 1, {2'b00, 2'b10, 2'b11, 1'b0, 28'h0});

        // Back-to-back writes and hits that leave history alone.
        do_reset();
        out_log.delete();
        send({3'b010, A}); send({3'b010, A}); send({3'b010, A});
        send({3'b010, B}); send({3'b010, A}); send({3'b010, A});
        drain();
        expect_log("wr_full", 0, {2'b01, 1'b0, A});
        expect_log("wr_hit1", 1, {2'b01, 3'b100, 2'b00, 28'h0});
        expect_log("wr_hit1_again", 2, {2'b01, 3'b100, 2'b00, 28'h0});
        expect_log("wr_full_b", 3, {2'b01, 1'b0, B});
        expect_log("wr_hit2", 4, {2'b01, 3'b100, 2'b01, 28'h0});
        expect_log("wr_hit2_nopush", 5, {2'b01, 3'b100, 2'b01, 28'h0});

        do_reset();
        out_log.delete();
        send({3'b010, 32'h0000_0005});
        send({3'b010, 32'hFFFF_8000});
        send({3'b010, 32'hFFFF_8000});
        for (int i = 0; i < 6; i++) send({3'b010, 32'h5000_0000 + 32'(i)});
        send({3'b010, 32'h5000_0000});
        drain();
        expect_log("wr_9bit", 0, {2'b01, 3'b110, 9'h005, 21'h0});
        expect_log("wr_16bit", 1, {2'b01, 3'b111, 16'h8000, 14'h0});
        expect_log("wr_16bit_hit", 2, {2'b01, 3'b100, 2'b00, 28'h0});
        expect_log("wr_far_hit", 9, {2'b01, 3'b101, 9'd5, 21'h0});

        out_log.delete();
        send({2'b10, 21'h0, 12'd16});
        send({2'b10, 21'h0, 12'd17});
        send({2'b10, 21'h0, 12'd2064});
        send({2'b10, 21'h0, 12'd0});
        send({2'b10, 21'h0, 12'd4095});
        send({2'b11, 5'h15, 28'hABC_DEF0});
        drain();
        expect_log("rd_16", 0, {2'b10, 1'b0, 4'hF, 28'h0});
        expect_log("rd_17", 1, {2'b10, 1'b1, 11'h000, 21'h0});
        expect_log("rd_2064", 2, {2'b10, 1'b1, 11'h7FF, 21'h0});
        expect_log("rd_0", 3, {2'b10, 1'b0, 4'h0, 28'h0});
        expect_log("rd_sat", 4, {2'b10, 1'b1, 11'h7FF, 21'h0});
        expect_log("special", 5, {2'b11, 5'h15, 28'h0});

        // Backpressure with a third word waiting at the input.
        out_log.delete();
        bus.i_busy = 1'b1;
        send({2'b10, 21'h0, 12'd1});
        send({2'b10, 21'h0, 12'd2});
        bus.i_stb = 1'b1;
        bus.i_word = {2'b10, 21'h0, 12'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_busy", bus.o_busy, 1'b1);
            chk1("bp_stb", bus.o_stb, 1'b1);
            chk("bp_word", bus.o_word, {2'b10, 1'b0, 4'h0, 28'h0});
        end
        sync();
        bus.i_busy = 1'b0;
        send({2'b10, 21'h0, 12'd3});
        drain();
        expect_log("bp_order0", 0, {2'b10, 1'b0, 4'h0, 28'h0});
        expect_log("bp_order1", 1, {2'b10, 1'b0, 4'h1, 28'h0});
        expect_log("bp_order2", 2, {2'b10, 1'b0, 4'h2, 28'h0});

        // Reset mid-stream, then reset after a full history.
        bus.i_busy = 1'b1;
        send({3'b010, A});
        send({3'b010, B});
        do_reset();
        @(negedge clk);
        chk1("midreset_stb", bus.o_stb, 1'b0);
        chk1("midreset_busy", bus.o_busy, 1'b0);
        chk1("midreset_active", o_active, 1'b0);
        sync();
        for (int i = 0; i < 9; i++) send({3'b010, 32'hA000_0000 + 32'h0101_0101 * 32'(i)});
        drain();
        do_reset();
        out_log.delete();
        send({3'b010, 32'hA000_0000});
        drain();
        expect_log("post_reset_full", 0, {2'b01, 1'b0, 32'hA000_0000});

        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.i_stb  = ($urandom_range(0, 3) != 0);
            bus.i_word = rand_word();
            bus.i_busy = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            sync();
        end
        rst = 1'b0;
        bus.i_stb = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
